// File: rtl/safety_display_ctrl.sv
// rtl/safety_display_ctrl.sv - arm/trip/ack conditioning and safety FSM driving frame-aligned pattern select

// Two-flop synchronizer followed by a counting debouncer: the filtered value
// only follows the synchronized input after CYCLES consecutive differing samples.
module sdc_debounce #(
    parameter logic [15:0] CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic db_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        db_q;
    logic [15:0] cnt_q;

    // Bring the asynchronous raw input into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count how long the synced value has disagreed with the filtered one; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q  <= 1'b0;
            cnt_q <= 16'd0;
        end else if (sync2_q == db_q) begin
            cnt_q <= 16'd0;
        end else if (cnt_q == CYCLES - 16'd1) begin
            db_q  <= sync2_q;
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign db_o = db_q;

endmodule

// Safety state machine with blink timing; the pattern select only moves on vsync rising edges.
module safety_display_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  BLINK_FRAMES    = 8'd30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_vs,
    input  logic       i_armed,
    input  logic       i_trip,
    input  logic       i_ack,
    output logic [1:0] o_pattern_select,
    output logic       o_alarm,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        DISARMED   = 2'd0,
        ARMED      = 2'd1,
        ALARM      = 2'd2,
        CLEAR_WAIT = 2'd3
    } state_t;

    logic       armed_db;
    logic       trip_db;
    logic       ack_db;
    logic       ack_db_d_q;
    logic       vs_d_q;
    logic       ack_pulse;
    logic       frame_tick;
    state_t     state_q;
    state_t     state_d;
    logic       alarm_q;
    logic [7:0] blink_cnt_q;
    logic       blink_phase_q;
    logic [1:0] pattern_q;
    logic [1:0] pattern_d;

    sdc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_armed (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (i_armed),
        .db_o    (armed_db)
    );

    sdc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_trip (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (i_trip),
        .db_o    (trip_db)
    );

    sdc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ack (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (i_ack),
        .db_o    (ack_db)
    );

    // Delayed copies for edge detection of the ack button and of vsync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_db_d_q <= 1'b0;
            vs_d_q     <= 1'b0;
        end else begin
            ack_db_d_q <= ack_db;
            vs_d_q     <= i_vs;
        end
    end

    assign ack_pulse  = ack_db & ~ack_db_d_q;
    assign frame_tick = i_vs & ~vs_d_q;

    // Next-state rules; a trip wins over a disarm, and disarming alone never leaves ALARM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DISARMED: begin
                if (armed_db) state_d = ARMED;
            end
            ARMED: begin
                if (trip_db)        state_d = ALARM;
                else if (!armed_db) state_d = DISARMED;
            end
            ALARM: begin
                if (ack_pulse) begin
                    if (trip_db)       state_d = CLEAR_WAIT;
                    else if (armed_db) state_d = ARMED;
                    else               state_d = DISARMED;
                end
            end
            CLEAR_WAIT: begin
                if (!trip_db) state_d = armed_db ? ARMED : DISARMED;
            end
            default: state_d = DISARMED;
        endcase
    end

    // State register with the alarm flag registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DISARMED;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= (state_d == ALARM);
        end
    end

    // Blink timer runs only in ALARM and is held cleared elsewhere so every alarm starts red.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (state_q != ALARM) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_FRAMES - 8'd1) begin
                blink_cnt_q   <= 8'd0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    // Colour wanted for the current state: white, green, red, or red/white blinking.
    always_comb begin
        pattern_d = 2'd0;
        case (state_q)
            DISARMED:   pattern_d = 2'd0;
            ARMED:      pattern_d = 2'd1;
            ALARM:      pattern_d = blink_phase_q ? 2'd0 : 2'd2;
            CLEAR_WAIT: pattern_d = 2'd2;
            default:    pattern_d = 2'd0;
        endcase
    end

    // Latch the wanted colour only at a frame boundary so a frame never mixes colours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= 2'd0;
        end else if (frame_tick) begin
            pattern_q <= pattern_d;
        end
    end

    assign o_pattern_select = pattern_q;
    assign o_alarm          = alarm_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_safety_display_ctrl.sv
// tb/tb_safety_display_ctrl.sv - self-checking bench for safety_display_ctrl
module tb_safety_display_ctrl;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int FRAME = 16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_vs    = 1'b0;
    logic       i_armed = 1'b0;
    logic       i_trip  = 1'b0;
    logic       i_ack   = 1'b0;
    logic [1:0] o_pattern_select;
    logic       o_alarm;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    logic vs_run = 1'b0;
    int   vs_cnt = 0;

    safety_display_ctrl #(
        .DEBOUNCE_CYCLES (16'd4),
        .BLINK_FRAMES    (8'd2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_vs             (i_vs),
        .i_armed          (i_armed),
        .i_trip           (i_trip),
        .i_ack            (i_ack),
        .o_pattern_select (o_pattern_select),
        .o_alarm          (o_alarm),
        .o_state          (o_state)
    );

    always #5 clk = ~clk;

    // Frame model: vsync high for the first 3 cycles of each FRAME-cycle frame.
    always @(negedge clk) begin
        if (vs_run) begin
            vs_cnt = (vs_cnt + 1) % FRAME;
            i_vs   = (vs_cnt < 3);
        end
    end

    // Reference model: a debounced value adopts a level once the raw input was
    // seen at that level on D consecutive edges, ending two edges ago.
    logic qa[$];
    logic qt[$];
    logic qk[$];
    logic m_arm, m_trip, m_ack, m_ack_d, m_vs_d, m_phase, m_tick, m_pulse;
    int   m_state, m_cnt, m_pat, m_ns;

    function automatic logic settle(input logic q[$], input logic cur);
        logic v;
        v = q[q.size()-2];
        for (int i = 2; i <= D + 1; i++)
            if (q[q.size()-i] !== v) return cur;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qa = {}; qt = {}; qk = {};
            for (int i = 0; i <= D; i++) begin
                qa.push_back(1'b0); qt.push_back(1'b0); qk.push_back(1'b0);
            end
            m_arm = 0; m_trip = 0; m_ack = 0; m_ack_d = 0; m_vs_d = 0;
            m_phase = 0; m_tick = 0; m_state = 0; m_cnt = 0; m_pat = 0;
        end else begin
            m_tick  = i_vs & ~m_vs_d;
            m_pulse = m_ack & ~m_ack_d;
            m_ns    = m_state;
            case (m_state)
                0: if (m_arm) m_ns = 1;
                1: if (m_trip) m_ns = 2; else if (!m_arm) m_ns = 0;
                2: if (m_pulse) m_ns = m_trip ? 3 : (m_arm ? 1 : 0);
                default: if (!m_trip) m_ns = m_arm ? 1 : 0;
            endcase
            if (m_tick)
                m_pat = (m_state == 0) ? 0 : (m_state == 1) ? 1 : (m_state == 3) ? 2 : (m_phase ? 0 : 2);
            if (m_state != 2) begin
                m_cnt = 0; m_phase = 0;
            end else if (m_tick) begin
                if (m_cnt == B - 1) begin m_cnt = 0; m_phase = ~m_phase; end
                else m_cnt++;
            end
            m_ack_d = m_ack;
            m_vs_d  = i_vs;
            m_arm   = settle(qa, m_arm);
            m_trip  = settle(qt, m_trip);
            m_ack   = settle(qk, m_ack);
            qa.push_back(i_armed); void'(qa.pop_front());
            qt.push_back(i_trip);  void'(qt.pop_front());
            qk.push_back(i_ack);   void'(qk.pop_front());
            m_state = m_ns;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_armed = 1'b0; i_trip = 1'b0; i_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vs_run  = 1'b1;
        cycles(3);
        checks++;
        if ({o_state, o_alarm, o_pattern_select} !== 5'd0) begin
            errors++;
            $display("FAIL reset_values: got state %0d alarm %0b pat %0d, required 0 0 0", o_state, o_alarm, o_pattern_select);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (o_state !== 2'd0 || o_pattern_select !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle: got state %0d pat %0d, required 0 0", o_state, o_pattern_select);
            end
        end
    endtask

    task automatic test_arm();
        int seen = 0;
        i_armed = 1'b1;
        for (int k = 1; k <= D + 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_state !== ((k >= D + 3) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL arm_latency edge %0d: got state %0d, required %0d", k, o_state, (k >= D + 3) ? 1 : 0);
            end
        end
        for (int c = 0; c < 3 * FRAME && seen == 0; c++) begin
            @(negedge clk);
            checks++;
            if (o_pattern_select !== (m_tick ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL arm_pattern: got %0d, required %0d", o_pattern_select, m_tick ? 1 : 0);
            end
            if (m_tick) seen = 1;
        end
        if (seen == 0) begin
            errors++;
            $display("FAIL arm_tick_timeout: got no frame tick, required one within %0d cycles", 3 * FRAME);
        end
    endtask

    task automatic test_glitch();
        int seq [6];
        int got = 0;
        seq = '{2, 2, 0, 0, 2, 2};
        do_reset();
        i_armed = 1'b1;
        cycles(D + 4);
        i_trip = 1'b1;
        cycles(3);
        i_trip = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (o_state !== 2'd1 || o_alarm !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject: got state %0d alarm %0b, required 1 0", o_state, o_alarm);
            end
        end
        i_trip = 1'b1;
        for (int k = 1; k <= D + 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_alarm !== (k >= D + 3)) begin
                errors++;
                $display("FAIL trip_latency edge %0d: got alarm %0b, required %0b", k, o_alarm, k >= D + 3);
            end
        end
        for (int c = 0; c < 10 * FRAME && got < 6; c++) begin
            @(negedge clk);
            if (m_tick) begin
                checks++;
                if (o_pattern_select !== 2'(seq[got])) begin
                    errors++;
                    $display("FAIL blink_seq tick %0d: got %0d, required %0d", got, o_pattern_select, seq[got]);
                end
                got++;
            end
        end
        if (got < 6) begin
            errors++;
            $display("FAIL blink_timeout: got %0d ticks, required 6", got);
        end
    endtask

    task automatic test_priority();
        do_reset();
        i_armed = 1'b1;
        cycles(D + 4);
        i_armed = 1'b0;
        i_trip  = 1'b1;
        for (int k = 1; k <= D + 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_state !== ((k >= D + 3) ? 2'd2 : 2'd1)) begin
                errors++;
                $display("FAIL priority edge %0d: got state %0d, required %0d", k, o_state, (k >= D + 3) ? 2 : 1);
            end
        end
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (o_state !== 2'd2 || o_pattern_select !== 2'(m_pat) || o_alarm !== 1'b1) begin
                errors++;
                $display("FAIL priority_hold: got state %0d pat %0d alarm %0b, required 2 %0d 1", o_state, o_pattern_select, o_alarm, m_pat);
            end
        end
    endtask

    task automatic test_ack();
        i_ack = 1'b1;
        cycles(D + 3);
        checks++;
        if (o_state !== 2'd3) begin
            errors++;
            $display("FAIL ack_clear_wait: got state %0d, required 3", o_state);
        end
        cycles(2 * FRAME);
        checks++;
        if (o_state !== 2'd3 || o_pattern_select !== 2'd2) begin
            errors++;
            $display("FAIL clear_wait_steady: got state %0d pat %0d, required 3 2", o_state, o_pattern_select);
        end
        i_trip = 1'b0;
        cycles(D + 3);
        checks++;
        if (o_state !== 2'd0) begin
            errors++;
            $display("FAIL clear_to_disarmed: got state %0d, required 0", o_state);
        end
        i_armed = 1'b1;
        i_trip  = 1'b1;
        cycles(D + 4);
        cycles(3 * FRAME);
        checks++;
        if (o_state !== 2'd2) begin
            errors++;
            $display("FAIL ack_held_no_repeat: got state %0d, required 2", o_state);
        end
        i_ack = 1'b0;
        cycles(D + 3);
        i_ack = 1'b1;
        cycles(D + 3);
        i_trip = 1'b0;
        cycles(D + 3);
        checks++;
        if (o_state !== 2'd1) begin
            errors++;
            $display("FAIL clear_to_armed: got state %0d, required 1", o_state);
        end
        i_ack = 1'b0;
    endtask

    task automatic test_frame_align();
        logic [1:0] prev;
        do_reset();
        i_armed = 1'b1;
        cycles(D + 3 + 2 * FRAME);
        while (vs_cnt != 8) @(negedge clk);
        i_armed = 1'b0;
        prev = o_pattern_select;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ((o_pattern_select !== prev && !m_tick) || o_pattern_select !== 2'(m_pat)) begin
                errors++;
                $display("FAIL frame_align: got pat %0d (prev %0d tick %0b), required %0d", o_pattern_select, prev, m_tick, m_pat);
            end
            prev = o_pattern_select;
        end
        vs_run  = 1'b0;
        i_armed = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (o_pattern_select !== 2'd0) begin
                errors++;
                $display("FAIL vs_stopped_freeze: got pat %0d, required 0", o_pattern_select);
            end
        end
        checks++;
        if (o_state !== 2'd1) begin
            errors++;
            $display("FAIL vs_stopped_state: got state %0d, required 1", o_state);
        end
        vs_run = 1'b1;
    endtask

    task automatic test_random();
        int left = 2500;
        do_reset();
        while (left > 0) begin
            int hold;
            i_armed = ($urandom_range(0, 3) != 0);
            i_trip  = ($urandom_range(0, 2) == 0);
            i_ack   = ($urandom_range(0, 2) == 0);
            hold    = $urandom_range(1, 3 * D);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                checks++;
                if (o_state !== 2'(m_state) || o_alarm !== (m_state == 2) || o_pattern_select !== 2'(m_pat)) begin
                    errors++;
                    $display("FAIL random_model: got state %0d alarm %0b pat %0d, required %0d %0b %0d",
                             o_state, o_alarm, o_pattern_select, m_state, m_state == 2, m_pat);
                end
            end
            left -= hold;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_armed = 1'b1;
        i_trip  = 1'b1;
        cycles(D + 6);
        checks++;
        if (o_alarm !== 1'b1) begin
            errors++;
            $display("FAIL mid_alarm_setup: got alarm %0b, required 1", o_alarm);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({o_state, o_alarm, o_pattern_select} !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got state %0d alarm %0b pat %0d, required 0 0 0", o_state, o_alarm, o_pattern_select);
        end
        i_armed = 1'b0;
        i_trip  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (o_state !== 2'd0 || o_pattern_select !== 2'd0) begin
                errors++;
                $display("FAIL post_reset_idle: got state %0d pat %0d, required 0 0", o_state, o_pattern_select);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_glitch();
        test_priority();
        test_ack();
        test_frame_align();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
